scfifomw_x: RTL

SCFIFOMW_X -- requirements
Module: scfifomw_x

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/scmwram.sv | 79 +++++++
 rtl/scfifomw_x.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared constants and helpers for the mixed-width FIFO family.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    localparam logic [23:0] c_order_lsb = "LSB";
    localparam logic [23:0] c_order_msb = "MSB";

    // Ratio of the wider to the narrower width.
    function automatic int ratio(input int a, input int b);
        return (a > b) ? (a / b) : (b / a);
    endfunction

    // Bits needed to hold 0..max_count.
    function automatic int used_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

    // Bit-lane of unit k inside an n-unit word.
    function automatic int lane(input int k, input int n, input bit msb_first);
        return msb_first ? (n - 1 - k) : k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scmwram.sv
`default_nettype none
// ============================================================================
// Module   : scmwram
// Brief    : Single-clock simple-dual-port mixed-width RAM, unit-addressed.
// Revision : 1.0
// ============================================================================
module scmwram
    import fifo_pkg::*;
#(
    parameter int FWIDTH = 16,
    parameter int SWIDTH = 8,
    parameter int SIZE   = 32,
    parameter     ORDER  = "LSB",
    parameter     REGOUT = "N",
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [FWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [SWIDTH-1:0] rdata
);

    localparam int c_u      = (FWIDTH < SWIDTH) ? FWIDTH : SWIDTH;
    localparam int c_nf     = FWIDTH / c_u;
    localparam int c_ns     = SWIDTH / c_u;
    localparam int c_depthu = SIZE * c_nf;
    localparam bit c_msb    = (ORDER != c_order_lsb);

    logic [c_u-1:0]    r_mem [c_depthu];
    logic [SWIDTH-1:0] r_rd;

    // Storage is not reset; the control logic never reads an unwritten unit.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < c_nf; k++) begin
                r_mem[waddr + AW'(k)] <= wdata[lane(k, c_nf, c_msb)*c_u +: c_u];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd <= '0;
        end else if (re) begin
            for (int k = 0; k < c_ns; k++) begin
                r_rd[lane(k, c_ns, c_msb)*c_u +: c_u] <= r_mem[raddr + AW'(k)];
            end
        end
    end

    generate
        if (REGOUT == "Y") begin : g_regout
            logic              r_vld;
            logic [SWIDTH-1:0] r_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= 1'b0;
                    r_q   <= '0;
                end else begin
                    r_vld <= re;
                    if (r_vld) begin
                        r_q <= r_rd;
                    end
                end
            end

            assign rdata = r_q;
        end else begin : g_direct
            assign rdata = r_rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/scfifomw_x.sv
`default_nettype none
// ============================================================================
// Module   : scfifomw_x
// Brief    : Single-clock mixed-width FIFO; occupancy kept in narrow units.
// Revision : 1.0
// ============================================================================
module scfifomw_x
    import fifo_pkg::*;
#(
    parameter int FWIDTH = 16,
    parameter int SWIDTH = 8,
    parameter int SIZE   = 32,
    parameter     ORDER  = "LSB",
    parameter     REGOUT = "N",
    parameter int AFULL  = SIZE - 4,
    parameter int AEMPTY = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [FWIDTH-1:0]                              data,
    input  logic                                           write,
    input  logic                                           read,
    output logic [SWIDTH-1:0]                              q,
    output logic                                           full,
    output logic                                           empty,
    output logic                                           afull,
    output logic                                           aempty,
    output logic [used_width(SIZE)-1:0]                    usedw,
    output logic [used_width(SIZE*FWIDTH/SWIDTH)-1:0]      usedr,
    output logic                                           ovf,
    output logic                                           udf
);

    localparam int c_r      = ratio(FWIDTH, SWIDTH);
    localparam int c_u      = (FWIDTH < SWIDTH) ? FWIDTH : SWIDTH;
    localparam int c_nf     = (FWIDTH >= SWIDTH) ? c_r : 1;
    localparam int c_ns     = (SWIDTH >= FWIDTH) ? c_r : 1;
    localparam int c_depthu = SIZE * c_nf;
    localparam int c_aw     = $clog2(c_depthu);
    localparam int c_cw     = used_width(c_depthu);
    localparam int c_ww     = used_width(SIZE);
    localparam int c_rw     = used_width(SIZE*FWIDTH/SWIDTH);

    localparam logic [c_cw-1:0] c_nf_cnt   = c_cw'(c_nf);
    localparam logic [c_cw-1:0] c_ns_cnt   = c_cw'(c_ns);
    localparam logic [c_cw-1:0] c_full_thr = c_cw'(c_depthu - c_nf);
    localparam logic [c_aw-1:0] c_nf_ptr   = c_aw'(c_nf);
    localparam logic [c_aw-1:0] c_ns_ptr   = c_aw'(c_ns);
    localparam logic [c_aw-1:0] c_wlast    = c_aw'(c_depthu - c_nf);
    localparam logic [c_aw-1:0] c_rlast    = c_aw'(c_depthu - c_ns);
    localparam logic [c_ww-1:0] c_afull    = c_ww'(AFULL);
    localparam logic [c_rw-1:0] c_aempty   = c_rw'(AEMPTY);

    generate
        if ((FWIDTH % SWIDTH != 0) && (SWIDTH % FWIDTH != 0)) begin : g_bad_ratio
            $error("scfifomw_x: FWIDTH and SWIDTH must be integer multiples");
        end
        if ((SIZE < 16) || ((SIZE & (SIZE - 1)) != 0)) begin : g_bad_size
            $error("scfifomw_x: SIZE must be a power of 2, at least 16");
        end
        if (c_depthu % c_ns != 0) begin : g_bad_depth
            $error("scfifomw_x: depth is not a whole number of read words");
        end
        if ((ORDER != c_order_lsb) && (ORDER != c_order_msb)) begin : g_bad_order
            $error("scfifomw_x: ORDER must be LSB or MSB");
        end
    endgenerate

    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_next;
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_ww-1:0] w_usedw_next;
    logic [c_rw-1:0] w_usedr_next;
    logic            w_wr_ok;
    logic            w_rd_ok;

    // Acceptance is judged on the registered flags only.
    always_comb begin
        w_wr_ok    = write & ~full;
        w_rd_ok    = read & ~empty;
        w_cnt_next = r_cnt;
        if (w_wr_ok) begin
            w_cnt_next = w_cnt_next + c_nf_cnt;
        end
        if (w_rd_ok) begin
            w_cnt_next = w_cnt_next - c_ns_cnt;
        end
        w_usedw_next = c_ww'(w_cnt_next / c_nf_cnt);
        w_usedr_next = c_rw'(w_cnt_next / c_ns_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
            usedw  <= '0;
            usedr  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_wr_ok) begin
                r_wptr <= (r_wptr == c_wlast) ? '0 : (r_wptr + c_nf_ptr);
            end
            if (w_rd_ok) begin
                r_rptr <= (r_rptr == c_rlast) ? '0 : (r_rptr + c_ns_ptr);
            end
            // A partial narrow-to-wide word stays below c_ns and keeps empty high.
            full   <= (w_cnt_next > c_full_thr);
            empty  <= (w_cnt_next < c_ns_cnt);
            afull  <= (w_usedw_next >= c_afull);
            aempty <= (w_usedr_next <= c_aempty);
            usedw  <= w_usedw_next;
            usedr  <= w_usedr_next;
            if (write && full) begin
                ovf <= 1'b1;
            end
            if (read && empty) begin
                udf <= 1'b1;
            end
        end
    end

    scmwram #(
        .FWIDTH (FWIDTH),
        .SWIDTH (SWIDTH),
        .SIZE   (SIZE),
        .ORDER  (ORDER),
        .REGOUT (REGOUT),
        .AW     (c_aw)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_ok),
        .waddr (r_wptr),
        .wdata (data),
        .re    (w_rd_ok),
        .raddr (r_rptr),
        .rdata (q)
    );

endmodule
`default_nettype wire
